// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: global reset / tristate sequencer.
// After the synchronised PLL lock is seen, holds gsr_o for ROC_CYCLES, then
// gts_o for a further TOC_CYCLES, then releases the enabled channel resets in
// ascending order, one every STEP_CYCLES. Lock loss or a software request
// reasserts everything and restarts the sequence.
module rst_seq_ctrl #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 16,
   parameter int ROC_CYCLES  = 8,
   parameter int TOC_CYCLES  = 2,
   parameter int STEP_CYCLES = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              pll_lock_i,
   input  logic              sw_rst_req_i,
   input  logic [NUM_CH-1:0] ch_en_i,
   output logic              gsr_o,
   output logic              gts_o,
   output logic [NUM_CH-1:0] ch_rst_o,
   output logic              done_o
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   // Terminal counts; the GTS value is only used when TOC_CYCLES is non-zero.
   localparam logic [CNT_W-1:0] ROC_LAST  = CNT_W'(ROC_CYCLES - 1);
   localparam logic [CNT_W-1:0] TOC_LAST  = CNT_W'(TOC_CYCLES - 1);
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_HOLD      = 3'd1,
      ST_GTS       = 3'd2,
      ST_SEQ       = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   state_t                 state_r, state_s;
   logic [CNT_W-1:0]       cnt_r, cnt_s;
   logic [NUM_CH-1:0]      en_q_r, en_q_s;
   logic                   gsr_r, gsr_s;
   logic                   gts_r, gts_s;
   logic [NUM_CH-1:0]      ch_rst_r, ch_rst_s;
   logic                   done_r, done_s;
   logic [SYNC_STAGES-1:0] sync_r;
   logic                   lock_s;
   logic [NUM_CH-1:0]      rem_s;
   logic [NUM_CH-1:0]      one_s;
   logic [IDX_W-1:0]       ch_idx_s;
   logic                   last_s;

   // Index of the lowest set bit (0 when the vector is empty).
   function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CH-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = {IDX_W{1'b0}};
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = IDX_W'(i);
         end
      end
      return idx;
   endfunction

   assign lock_s = sync_r[SYNC_STAGES-1];

   // Lock synchroniser: pll_lock_i is asynchronous to clk_i.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], pll_lock_i};
      end
   end

   // Current channel: lowest enabled channel still held in reset.
   always_comb begin
      rem_s             = en_q_r & ch_rst_r;
      ch_idx_s          = lowest_idx(rem_s);
      one_s             = {NUM_CH{1'b0}};
      one_s[ch_idx_s]   = 1'b1;
      last_s            = ((rem_s & ~one_s) == {NUM_CH{1'b0}});
   end

   // Next-state and next-output logic; restart events override progression.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      en_q_s   = en_q_r;
      gsr_s    = gsr_r;
      gts_s    = gts_r;
      ch_rst_s = ch_rst_r;
      done_s   = done_r;
      case (state_r)
         ST_WAIT_LOCK: begin
            if (lock_s) begin
               state_s = ST_HOLD;
               cnt_s   = {CNT_W{1'b0}};
               en_q_s  = ch_en_i;
            end else begin
               state_s = ST_WAIT_LOCK;
            end
         end
         ST_HOLD: begin
            if (cnt_r == ROC_LAST) begin
               gsr_s = 1'b0;
               cnt_s = {CNT_W{1'b0}};
               if (TOC_CYCLES == 0) begin
                  gts_s = 1'b0;
                  if (en_q_r == {NUM_CH{1'b0}}) begin
                     state_s = ST_DONE;
                     done_s  = 1'b1;
                  end else begin
                     state_s = ST_SEQ;
                  end
               end else begin
                  state_s = ST_GTS;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_GTS: begin
            if (cnt_r == TOC_LAST) begin
               gts_s = 1'b0;
               cnt_s = {CNT_W{1'b0}};
               if (en_q_r == {NUM_CH{1'b0}}) begin
                  state_s = ST_DONE;
                  done_s  = 1'b1;
               end else begin
                  state_s = ST_SEQ;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_SEQ: begin
            if (rem_s == {NUM_CH{1'b0}}) begin
               state_s = ST_DONE;
               done_s  = 1'b1;
            end else if (cnt_r == STEP_LAST) begin
               ch_rst_s[ch_idx_s] = 1'b0;
               cnt_s              = {CNT_W{1'b0}};
               if (last_s) begin
                  state_s = ST_DONE;
                  done_s  = 1'b1;
               end else begin
                  state_s = ST_SEQ;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_DONE: begin
            state_s = ST_DONE;
         end
         default: begin
            state_s  = ST_WAIT_LOCK;
            cnt_s    = {CNT_W{1'b0}};
            gsr_s    = 1'b1;
            gts_s    = 1'b1;
            ch_rst_s = {NUM_CH{1'b1}};
            done_s   = 1'b0;
         end
      endcase

      if (state_r != ST_WAIT_LOCK) begin
         if (!lock_s) begin
            state_s  = ST_WAIT_LOCK;
            cnt_s    = {CNT_W{1'b0}};
            gsr_s    = 1'b1;
            gts_s    = 1'b1;
            ch_rst_s = {NUM_CH{1'b1}};
            done_s   = 1'b0;
         end else if (sw_rst_req_i) begin
            state_s  = ST_HOLD;
            cnt_s    = {CNT_W{1'b0}};
            en_q_s   = ch_en_i;
            gsr_s    = 1'b1;
            gts_s    = 1'b1;
            ch_rst_s = {NUM_CH{1'b1}};
            done_s   = 1'b0;
         end else begin
            en_q_s = en_q_s;
         end
      end else begin
         en_q_s = en_q_s;
      end
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r  <= ST_WAIT_LOCK;
         cnt_r    <= {CNT_W{1'b0}};
         en_q_r   <= {NUM_CH{1'b0}};
         gsr_r    <= 1'b1;
         gts_r    <= 1'b1;
         ch_rst_r <= {NUM_CH{1'b1}};
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         en_q_r   <= en_q_s;
         gsr_r    <= gsr_s;
         gts_r    <= gts_s;
         ch_rst_r <= ch_rst_s;
         done_r   <= done_s;
      end
   end

   assign gsr_o    = gsr_r;
   assign gts_o    = gts_r;
   assign ch_rst_o = ch_rst_r;
   assign done_o   = done_r;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: two instances (TOC=2 and TOC=0) share
// stimulus. Expected output transitions come from a timeline model and are
// queued; a monitor pops one entry per observed output change.
module tb_rst_seq_ctrl;
   localparam int ROC   = 8;
   localparam int TOC_A = 2;
   localparam int TOC_B = 0;
   localparam int STEP  = 4;
   localparam int SYNC  = 2;
   localparam logic [6:0] ALL_ON = 7'b1111110; // {gsr, gts, ch[3:0], done}

   typedef struct packed {
      int         t;
      logic [6:0] v;
   } exp_t;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       lock  = 1'b1;
   logic       sw    = 1'b0;
   logic [3:0] en_in = 4'hF;
   logic       gsr_a, gts_a, done_a, gsr_b, gts_b, done_b;
   logic [3:0] ch_a, ch_b;
   int         cyc     = 0;
   int         n_tests = 0;
   int         n_fail  = 0;
   bit         stim_done = 1'b0;
   exp_t       q_a[$];
   exp_t       q_b[$];

   rst_seq_ctrl #(.NUM_CH(4), .CNT_W(16), .ROC_CYCLES(ROC), .TOC_CYCLES(TOC_A),
                  .STEP_CYCLES(STEP), .SYNC_STAGES(SYNC)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .pll_lock_i(lock), .sw_rst_req_i(sw),
      .ch_en_i(en_in), .gsr_o(gsr_a), .gts_o(gts_a), .ch_rst_o(ch_a), .done_o(done_a));

   rst_seq_ctrl #(.NUM_CH(4), .CNT_W(16), .ROC_CYCLES(ROC), .TOC_CYCLES(TOC_B),
                  .STEP_CYCLES(STEP), .SYNC_STAGES(SYNC)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .pll_lock_i(lock), .sw_rst_req_i(sw),
      .ch_en_i(en_in), .gsr_o(gsr_b), .gts_o(gts_b), .ch_rst_o(ch_b), .done_o(done_b));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected outputs after edge t for a sequence whose HOLD starts at edge h.
   function automatic logic [6:0] vec_at(int t, int h, logic [3:0] en, int toc);
      int g, s, k, fin;
      logic [3:0] ch;
      g = h + ROC;
      s = g + toc;
      k = 0;
      fin = s;
      ch = 4'hF;
      for (int i = 0; i < 4; i++) begin
         if (en[i]) begin
            k++;
            fin = s + k * STEP;
            if (t >= fin) ch[i] = 1'b0;
         end
      end
      return {(t < g), (t < s), ch, (t >= fin)};
   endfunction

   function automatic int seq_end(int h, logic [3:0] en, int toc);
      return h + ROC + toc + $countones(en) * STEP;
   endfunction

   function automatic int rnd(int lo, int hi);
      return lo + int'($urandom() % 32'(hi - lo + 1));
   endfunction

   // Queue every transition of the sequence started at h that happens
   // before edge stop, plus the reassertion at stop when requested.
   task automatic push_seg(int h, logic [3:0] en, int stop, bit reassert);
      int toc, last;
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         toc  = (d == 0) ? TOC_A : TOC_B;
         last = seq_end(h, en, toc);
         for (int t = h + 1; t < stop && t <= last; t++) begin
            if (vec_at(t, h, en, toc) != vec_at(t - 1, h, en, toc)) begin
               e.t = t;
               e.v = vec_at(t, h, en, toc);
               if (d == 0) q_a.push_back(e); else q_b.push_back(e);
            end
         end
         if (reassert && vec_at(stop - 1, h, en, toc) != ALL_ON) begin
            e.t = stop;
            e.v = ALL_ON;
            if (d == 0) q_a.push_back(e); else q_b.push_back(e);
         end
      end
   endtask

   // Move to 2 time units after edge n (inputs driven there are sampled at n+1).
   task automatic to_edge(int n);
      while (cyc < n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Stimulus: random restart events with the expected timeline queued first.
   initial begin
      int h, last, p, n, d, r, l, a, act;
      logic [3:0] en, nen;
      bit co;
      en = 4'hF;
      to_edge(3);
      rst = 1'b0;
      h = 3 + SYNC + 1;
      for (int i = 0; i < 30; i++) begin
         last = seq_end(h, en, TOC_A);
         if (i == 0) nen = 4'b0101;
         else if (i == 1 || i == 4) nen = 4'b0000;
         else if (i == 2) nen = 4'hF;
         else nen = 4'(rnd(0, 15));
         act = (i < 3) ? i : rnd(0, 2);
         case (act)
            0: begin
               p = (i == 0) ? last + 2 : h + rnd(0, last - h + 4);
               n = (i == 0) ? 1 : rnd(1, 3);
               push_seg(h, en, p + 1, 1'b1);
               to_edge(p);
               sw = 1'b1;
               en_in = nen;
               to_edge(p + n);
               sw = 1'b0;
               h = p + n;
               en = nen;
            end
            1: begin
               d  = h + rnd(0, last - h + 4);
               r  = d + SYNC + 1;
               co = (i == 1) ? 1'b1 : bit'(rnd(0, 1));
               l  = r + rnd(0, 4);
               push_seg(h, en, r, 1'b1);
               to_edge(d);
               lock = 1'b0;
               if (co) begin
                  to_edge(r - 1);
                  sw = 1'b1;
                  to_edge(r);
                  sw = 1'b0;
               end
               to_edge(l);
               en_in = nen;
               lock = 1'b1;
               h = l + SYNC + 1;
               en = nen;
            end
            default: begin
               a = h + rnd(0, last - h + 4);
               push_seg(h, en, a + 1, 1'b0);
               to_edge(a);
               @(negedge clk);
               #3;
               rst = 1'b1;
               to_edge(a + 2);
               en_in = nen;
               rst = 1'b0;
               h = a + 2 + SYNC + 1;
               en = nen;
            end
         endcase
      end
      last = seq_end(h, en, TOC_A);
      push_seg(h, en, last + 1, 1'b0);
      to_edge(last + 6);
      stim_done = 1'b1;
   end

   // Monitor: checks reset values (also right after an async assertion)
   // and matches every output change against the scoreboard.
   initial begin
      logic [6:0] prev [2];
      logic [6:0] cur;
      exp_t e;
      prev[0] = ALL_ON;
      prev[1] = ALL_ON;
      forever begin
         @(negedge clk or posedge rst);
         #1;
         for (int d = 0; d < 2; d++) begin
            cur = (d == 0) ? {gsr_a, gts_a, ch_a, done_a} : {gsr_b, gts_b, ch_b, done_b};
            if (rst) begin
               n_tests++;
               if (cur != ALL_ON) begin
                  n_fail++;
                  $display("FAIL reset_state dut%0d cyc %0d: got %b, expected %b", d, cyc, cur, ALL_ON);
               end
               prev[d] = ALL_ON;
            end else if (cur != prev[d]) begin
               n_tests++;
               if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
                  n_fail++;
                  $display("FAIL unexpected_change dut%0d edge %0d: got %b, expected no change from %b",
                           d, cyc, cur, prev[d]);
               end else begin
                  if (d == 0) e = q_a.pop_front(); else e = q_b.pop_front();
                  if (e.t != cyc || e.v != cur) begin
                     n_fail++;
                     $display("FAIL transition dut%0d: got %b at edge %0d, expected %b at edge %0d",
                              d, cur, cyc, e.v, e.t);
                  end
               end
               prev[d] = cur;
            end
         end
         if (stim_done) begin
            n_tests++;
            if (q_a.size() + q_b.size() != 0) begin
               n_fail++;
               $display("FAIL pending_events: got %0d unseen transitions, expected 0",
                        q_a.size() + q_b.size());
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
         end
      end
   end

endmodule
